// File: rtl/rfarb_pkg.sv
// rtl/rfarb_pkg.sv - shared types and default widths for the register-file read arbiter
package rfarb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, scans from last+1 upward modulo NUM_REQ
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!grant_valid && req[pos]) begin
                grant_valid = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = pos;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares one reg-file read port among NUM_REQ requesters
// Optional write-port bypass into the captured data: RFARB_WR_BYPASS_EN
module regfile_read_arbiter
    import rfarb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rf_sel,
    input  logic [DATA_W-1:0]         rf_data,
`ifdef RFARB_WR_BYPASS_EN
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
`endif
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  sel_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  rd_data;
    logic               wr_hit;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               arb_en;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last        (last_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_any)
    );

`ifdef RFARB_WR_BYPASS_EN
    assign wr_hit  = wr_en && (wr_addr == sel_q) && (sel_q != '0);
    assign rd_data = wr_hit ? wr_data : rf_data;
`else
    assign wr_hit  = 1'b0;
    assign rd_data = rf_data;
`endif

    // Only the granted requester's rsp_ready can open the arbitration window in RESP.
    assign arb_en = reset_n && ((state_q == IDLE) ||
                               ((state_q == RESP) && rsp_ready[gnt_q]));
    assign accept = arb_en && arb_any;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        if (arb_en) begin
            req_ready = arb_grant;
        end
        case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = RESP;
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) state_d = accept ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_q  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                gnt_q  <= arb_idx;
                last_q <= arb_idx;
            end
            if (state_q == READ) begin
                data_q <= rd_data;
            end else if ((state_q == RESP) && wr_hit) begin
                data_q <= rd_data;
            end
        end
    end

    assign rf_sel   = sel_q;
    assign rsp_data = data_q;
    assign busy     = (state_q != IDLE);

endmodule
